// File: rtl/iir_mon_pkg.sv
// Shared constants for the IIR output-stream monitor: register map, STATUS layout
// and accumulator widths.
package iir_mon_pkg;

    localparam int SUM_W      = 48;
    localparam int CNT_W      = 16;
    localparam int DECIM_W    = 8;
    localparam int FIFO_DEPTH = 16;
    localparam int FIFO_AW    = $clog2(FIFO_DEPTH);

    localparam logic [3:0] REG_CTRL      = 4'd0;
    localparam logic [3:0] REG_DECIM     = 4'd1;
    localparam logic [3:0] REG_STATUS    = 4'd2;
    localparam logic [3:0] REG_FIFO_DATA = 4'd3;
    localparam logic [3:0] REG_MIN       = 4'd4;
    localparam logic [3:0] REG_MAX       = 4'd5;
    localparam logic [3:0] REG_SUM_LO    = 4'd6;
    localparam logic [3:0] REG_SUM_HI    = 4'd7;
    localparam logic [3:0] REG_COUNT     = 4'd8;

    localparam int CTRL_EN_BIT  = 0;
    localparam int CTRL_CLR_BIT = 1;

    localparam int ST_EMPTY   = 0;
    localparam int ST_FULL    = 1;
    localparam int ST_OVF     = 2;
    localparam int ST_FDONE   = 3;
    localparam int ST_LVL_LSB = 8;

    function automatic logic [SUM_W-1:0] sext_sum(input logic [31:0] s);
        return {{(SUM_W-32){s[31]}}, s};
    endfunction

endpackage

// File: rtl/iir_mon_fifo.sv
// Capture FIFO with first-word-fall-through head; a push into a full FIFO only
// lands when a pop frees the slot in the same cycle.
module iir_mon_fifo #(
    parameter int DW    = 32,
    parameter int DEPTH = iir_mon_pkg::FIFO_DEPTH,
    localparam int PW   = $clog2(DEPTH)
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,
    input  logic          clr,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] head,
    output logic          full,
    output logic          empty,
    output logic [PW:0]   level
);

    logic [DW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (PW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~clr & (~full | pop);
    assign do_pop  = pop & ~clr & ~empty;
    assign head    = mem[rd_ptr];
    assign level   = count;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i || clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // storage needs no reset: pointers and count define what is valid
    always_ff @(posedge wb_clk_i) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/iir_stream_monitor.sv
// Wishbone-mapped monitor for the IIR filter output: decimated capture FIFO plus
// per-frame min/max/sum/count statistics.
module iir_stream_monitor #(
    parameter int DW         = 32,
    parameter int AW         = 32,
    parameter int FIFO_DEPTH = iir_mon_pkg::FIFO_DEPTH
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,
    input  logic          in_valid_i,
    input  logic [DW-1:0] in_data_i,
    input  logic          in_last_i,
    input  logic [AW-1:0] wb_adr_i,
    input  logic          wb_cyc_i,
    input  logic          wb_stb_i,
    input  logic          wb_we_i,
    input  logic [3:0]    wb_sel_i,
    input  logic [DW-1:0] wb_dat_i,
    output logic [DW-1:0] wb_dat_o,
    output logic          wb_ack_o,
    output logic          wb_err_o,
    output logic          int_o
);

    import iir_mon_pkg::*;

    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    logic [3:0]         reg_idx;
    logic               bus_wr;
    logic               bus_rd;
    logic               clr_pulse;
    logic               decim_wr;
    logic               fifo_pop;
    logic               sample_acc;
    logic               push_req;

    logic               enable_q;
    logic [DECIM_W-1:0] decim_q;
    logic [DECIM_W-1:0] phase_cnt;
    logic               overflow_q;
    logic               frame_done_q;
    logic               in_frame_q;
    logic [DW-1:0]      min_q;
    logic [DW-1:0]      max_q;
    logic [SUM_W-1:0]   sum_q;
    logic [CNT_W-1:0]   count_q;

    logic [DW-1:0]      fifo_head;
    logic               fifo_full;
    logic               fifo_empty;
    logic [LVL_W-1:0]   fifo_level;
    logic [DW-1:0]      status_word;
    logic               unused_bus_bits;

    assign reg_idx    = wb_adr_i[5:2];
    assign bus_wr     = wb_cyc_i & wb_stb_i & wb_we_i;
    assign bus_rd     = wb_cyc_i & wb_stb_i & ~wb_we_i;
    assign clr_pulse  = bus_wr & (reg_idx == REG_CTRL) & wb_dat_i[CTRL_CLR_BIT];
    assign decim_wr   = bus_wr & (reg_idx == REG_DECIM);
    assign fifo_pop   = bus_rd & (reg_idx == REG_FIFO_DATA);
    assign sample_acc = in_valid_i & enable_q & ~clr_pulse;
    assign push_req   = sample_acc & (phase_cnt == '0);

    assign wb_ack_o = wb_cyc_i & wb_stb_i;
    assign wb_err_o = 1'b0;
    assign int_o    = frame_done_q | overflow_q;

    assign unused_bus_bits = ^{wb_sel_i, wb_adr_i[AW-1:6], wb_adr_i[1:0], wb_dat_i[DW-1:DECIM_W]};

    iir_mon_fifo #(
        .DW    (DW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .wb_clk_i (wb_clk_i),
        .wb_rst_i (wb_rst_i),
        .clr      (clr_pulse),
        .push     (push_req),
        .pop      (fifo_pop),
        .wdata    (in_data_i),
        .head     (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .level    (fifo_level)
    );

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            enable_q <= 1'b0;
            decim_q  <= '0;
        end else begin
            if (bus_wr && reg_idx == REG_CTRL) enable_q <= wb_dat_i[CTRL_EN_BIT];
            if (decim_wr)                      decim_q  <= wb_dat_i[DECIM_W-1:0];
        end
    end

    // decimation timer counts down from DECIM; a push happens at terminal count
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i || clr_pulse || decim_wr) begin
            phase_cnt <= '0;
        end else if (sample_acc) begin
            if (in_last_i)              phase_cnt <= '0;
            else if (phase_cnt == '0)   phase_cnt <= decim_q;
            else                        phase_cnt <= phase_cnt - DECIM_W'(1);
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i || clr_pulse) begin
            overflow_q <= 1'b0;
        end else if (push_req && fifo_full && !fifo_pop) begin
            overflow_q <= 1'b1;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i || clr_pulse) begin
            min_q        <= '0;
            max_q        <= '0;
            sum_q        <= '0;
            count_q      <= '0;
            frame_done_q <= 1'b0;
            in_frame_q   <= 1'b0;
        end else if (sample_acc) begin
            if (!in_frame_q) begin
                min_q   <= in_data_i;
                max_q   <= in_data_i;
                sum_q   <= sext_sum(in_data_i);
                count_q <= CNT_W'(1);
            end else begin
                if ($signed(in_data_i) < $signed(min_q)) min_q <= in_data_i;
                if ($signed(in_data_i) > $signed(max_q)) max_q <= in_data_i;
                sum_q <= sum_q + sext_sum(in_data_i);
                if (count_q != '1) count_q <= count_q + CNT_W'(1);
            end
            // inside a frame frame_done is already 0, so this also covers the first sample
            frame_done_q <= in_last_i;
            in_frame_q   <= ~in_last_i;
        end
    end

    always_comb begin
        status_word                          = '0;
        status_word[ST_EMPTY]                = fifo_empty;
        status_word[ST_FULL]                 = fifo_full;
        status_word[ST_OVF]                  = overflow_q;
        status_word[ST_FDONE]                = frame_done_q;
        status_word[ST_LVL_LSB +: LVL_W]     = fifo_level;
    end

    always_comb begin
        wb_dat_o = '0;
        case (reg_idx)
            REG_CTRL:      wb_dat_o[CTRL_EN_BIT] = enable_q;
            REG_DECIM:     wb_dat_o = {{(DW-DECIM_W){1'b0}}, decim_q};
            REG_STATUS:    wb_dat_o = status_word;
            REG_FIFO_DATA: wb_dat_o = fifo_empty ? '0 : fifo_head;
            REG_MIN:       wb_dat_o = min_q;
            REG_MAX:       wb_dat_o = max_q;
            REG_SUM_LO:    wb_dat_o = sum_q[DW-1:0];
            REG_SUM_HI:    wb_dat_o = {{(2*DW-SUM_W){sum_q[SUM_W-1]}}, sum_q[SUM_W-1:DW]};
            REG_COUNT:     wb_dat_o = {{(DW-CNT_W){1'b0}}, count_q};
            default:       wb_dat_o = '0;
        endcase
    end

endmodule

// File: tb/tb_iir_stream_monitor.sv
// Directed bench for iir_stream_monitor: hand-computed expectations per scenario.
module tb_iir_stream_monitor;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i;
    logic        in_valid_i;
    logic [31:0] in_data_i;
    logic        in_last_i;
    logic [31:0] wb_adr_i;
    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic        wb_we_i;
    logic [3:0]  wb_sel_i;
    logic [31:0] wb_dat_i;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;
    logic        wb_err_o;
    logic        int_o;

    int tests  = 0;
    int failed = 0;

    iir_stream_monitor dut (
        .wb_clk_i   (wb_clk_i),
        .wb_rst_i   (wb_rst_i),
        .in_valid_i (in_valid_i),
        .in_data_i  (in_data_i),
        .in_last_i  (in_last_i),
        .wb_adr_i   (wb_adr_i),
        .wb_cyc_i   (wb_cyc_i),
        .wb_stb_i   (wb_stb_i),
        .wb_we_i    (wb_we_i),
        .wb_sel_i   (wb_sel_i),
        .wb_dat_i   (wb_dat_i),
        .wb_dat_o   (wb_dat_o),
        .wb_ack_o   (wb_ack_o),
        .wb_err_o   (wb_err_o),
        .int_o      (int_o)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    task automatic tick();
        @(posedge wb_clk_i);
        #1;
    endtask

    task automatic wb_write(input int idx, input logic [31:0] d);
        wb_adr_i = 32'(idx) << 2;
        wb_dat_i = d;
        wb_we_i  = 1'b1;
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        tick();
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        wb_we_i  = 1'b0;
    endtask

    task automatic wb_read(input int idx, output logic [31:0] d);
        wb_adr_i = 32'(idx) << 2;
        wb_we_i  = 1'b0;
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        #1;
        d = wb_dat_o;
        tick();
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
    endtask

    task automatic send(input logic [31:0] d, input logic last);
        in_valid_i = 1'b1;
        in_data_i  = d;
        in_last_i  = last;
        tick();
        in_valid_i = 1'b0;
        in_last_i  = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] got;
        wb_adr_i = '0;
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        #1;
        tests++;
        if (wb_dat_o !== 32'h0) begin failed++; $display("FAIL reset_dat_idx0 got=%h exp=%h", wb_dat_o, 32'h0); end
        tests++;
        if (wb_ack_o !== 1'b1 || wb_err_o !== 1'b0) begin
            failed++; $display("FAIL reset_ack got=%b/%b exp=1/0", wb_ack_o, wb_err_o);
        end
        tick();
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        wb_read(2, got);
        tests++;
        if (got !== 32'h1) begin failed++; $display("FAIL reset_status got=%h exp=%h", got, 32'h1); end
        wb_read(8, got);
        tests++;
        if (got !== 32'h0) begin failed++; $display("FAIL reset_count got=%h exp=%h", got, 32'h0); end
        tests++;
        if (int_o !== 1'b0) begin failed++; $display("FAIL reset_int got=%b exp=0", int_o); end
    endtask

    task automatic test_basic();
        logic [31:0] got;
        logic [31:0] vals [5] = '{32'd3, 32'hFFFF_FFF9, 32'd10, 32'd0, 32'd2};
        int          idxs [5] = '{4, 5, 6, 7, 8};
        logic [31:0] exps [5] = '{32'hFFFF_FFF9, 32'd10, 32'd8, 32'd0, 32'd5};
        wb_write(0, 32'h1);
        wb_write(1, 32'h0);
        for (int i = 0; i < 5; i++) send(vals[i], i == 4);
        tick();
        wb_read(2, got);
        tests++;
        if (got !== 32'h508) begin failed++; $display("FAIL basic_status got=%h exp=%h", got, 32'h508); end
        tests++;
        if (int_o !== 1'b1) begin failed++; $display("FAIL basic_int got=%b exp=1", int_o); end
        for (int i = 0; i < 5; i++) begin
            wb_read(idxs[i], got);
            tests++;
            if (got !== exps[i]) begin failed++; $display("FAIL basic_stat_idx%0d got=%h exp=%h", idxs[i], got, exps[i]); end
        end
        for (int i = 0; i < 5; i++) begin
            wb_read(3, got);
            tests++;
            if (got !== vals[i]) begin failed++; $display("FAIL basic_pop%0d got=%h exp=%h", i, got, vals[i]); end
        end
        wb_read(2, got);
        tests++;
        if (got !== 32'h9) begin failed++; $display("FAIL basic_status_drained got=%h exp=%h", got, 32'h9); end
    endtask

    task automatic test_decim();
        logic [31:0] got;
        logic [31:0] exp_pop [5] = '{32'd0, 32'd3, 32'd6, 32'd9, 32'd100};
        wb_write(1, 32'd2);
        for (int i = 0; i < 10; i++) send(32'(i), i == 9);
        wb_read(2, got);
        tests++;
        if (got !== 32'h408) begin failed++; $display("FAIL decim_status got=%h exp=%h", got, 32'h408); end
        send(32'd100, 1'b0);
        send(32'd101, 1'b1);
        wb_read(2, got);
        tests++;
        if (got !== 32'h508) begin failed++; $display("FAIL decim_status_f2 got=%h exp=%h", got, 32'h508); end
        wb_read(6, got);
        tests++;
        if (got !== 32'd201) begin failed++; $display("FAIL decim_sum_f2 got=%h exp=%h", got, 32'd201); end
        wb_read(8, got);
        tests++;
        if (got !== 32'd2) begin failed++; $display("FAIL decim_count_f2 got=%h exp=%h", got, 32'd2); end
        for (int i = 0; i < 5; i++) begin
            wb_read(3, got);
            tests++;
            if (got !== exp_pop[i]) begin failed++; $display("FAIL decim_pop%0d got=%h exp=%h", i, got, exp_pop[i]); end
        end
        wb_read(1, got);
        tests++;
        if (got !== 32'd2) begin failed++; $display("FAIL decim_readback got=%h exp=%h", got, 32'd2); end
        wb_write(1, 32'd0);
    endtask

    task automatic test_overflow();
        logic [31:0] got;
        for (int i = 0; i < 20; i++) send(32'(i), 1'b0);
        wb_read(2, got);
        tests++;
        if (got !== 32'h1006) begin failed++; $display("FAIL ovf_status got=%h exp=%h", got, 32'h1006); end
        tests++;
        if (int_o !== 1'b1) begin failed++; $display("FAIL ovf_int got=%b exp=1", int_o); end
        // pop and push in the same cycle while full
        wb_adr_i   = 32'd12;
        wb_we_i    = 1'b0;
        wb_cyc_i   = 1'b1;
        wb_stb_i   = 1'b1;
        in_valid_i = 1'b1;
        in_data_i  = 32'd99;
        #1;
        got = wb_dat_o;
        tick();
        wb_cyc_i   = 1'b0;
        wb_stb_i   = 1'b0;
        in_valid_i = 1'b0;
        tests++;
        if (got !== 32'd0) begin failed++; $display("FAIL ovf_pushpop_head got=%h exp=%h", got, 32'd0); end
        wb_read(2, got);
        tests++;
        if (got !== 32'h1006) begin failed++; $display("FAIL ovf_pushpop_status got=%h exp=%h", got, 32'h1006); end
        wb_read(3, got);
        tests++;
        if (got !== 32'd1) begin failed++; $display("FAIL ovf_next_head got=%h exp=%h", got, 32'd1); end
        wb_write(0, 32'h3);
        wb_read(2, got);
        tests++;
        if (got !== 32'h1) begin failed++; $display("FAIL ovf_clear_status got=%h exp=%h", got, 32'h1); end
        tests++;
        if (int_o !== 1'b0) begin failed++; $display("FAIL ovf_clear_int got=%b exp=0", int_o); end
        wb_read(0, got);
        tests++;
        if (got !== 32'h1) begin failed++; $display("FAIL ovf_ctrl_readback got=%h exp=%h", got, 32'h1); end
    endtask

    task automatic test_disable();
        logic [31:0] got;
        send(32'd4, 1'b0);
        wb_write(0, 32'h0);
        send(32'd50, 1'b0);
        wb_write(0, 32'h1);
        send(32'd6, 1'b1);
        wb_read(8, got);
        tests++;
        if (got !== 32'd2) begin failed++; $display("FAIL dis_count got=%h exp=%h", got, 32'd2); end
        wb_read(5, got);
        tests++;
        if (got !== 32'd6) begin failed++; $display("FAIL dis_max got=%h exp=%h", got, 32'd6); end
        wb_read(6, got);
        tests++;
        if (got !== 32'd10) begin failed++; $display("FAIL dis_sum got=%h exp=%h", got, 32'd10); end
        wb_read(2, got);
        tests++;
        if (got !== 32'h208) begin failed++; $display("FAIL dis_status got=%h exp=%h", got, 32'h208); end
        wb_write(0, 32'h3);
    endtask

    task automatic test_sum_wrap();
        logic [31:0] got;
        int          idxs [5] = '{4, 5, 6, 7, 8};
        logic [31:0] exps [5] = '{32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFC, 32'h1, 32'd4};
        for (int i = 0; i < 3; i++) send(32'h7FFF_FFFF, 1'b0);
        send(32'hFFFF_FFFF, 1'b1);
        for (int i = 0; i < 5; i++) begin
            wb_read(idxs[i], got);
            tests++;
            if (got !== exps[i]) begin failed++; $display("FAIL wrap_idx%0d got=%h exp=%h", idxs[i], got, exps[i]); end
        end
        wb_write(0, 32'h3);
    endtask

    task automatic test_empty_pop();
        logic [31:0] got;
        wb_read(3, got);
        tests++;
        if (got !== 32'd0) begin failed++; $display("FAIL empty_pop got=%h exp=%h", got, 32'd0); end
        wb_read(2, got);
        tests++;
        if (got !== 32'h1) begin failed++; $display("FAIL empty_pop_status got=%h exp=%h", got, 32'h1); end
        // clear and a valid sample in the same cycle
        in_valid_i = 1'b1;
        in_data_i  = 32'd55;
        wb_write(0, 32'h3);
        in_valid_i = 1'b0;
        wb_read(8, got);
        tests++;
        if (got !== 32'd0) begin failed++; $display("FAIL clr_wins_count got=%h exp=%h", got, 32'd0); end
        // pop and push together on an empty FIFO
        wb_adr_i   = 32'd12;
        wb_we_i    = 1'b0;
        wb_cyc_i   = 1'b1;
        wb_stb_i   = 1'b1;
        in_valid_i = 1'b1;
        in_data_i  = 32'd77;
        #1;
        got = wb_dat_o;
        tick();
        wb_cyc_i   = 1'b0;
        wb_stb_i   = 1'b0;
        in_valid_i = 1'b0;
        tests++;
        if (got !== 32'd0) begin failed++; $display("FAIL empty_pushpop_head got=%h exp=%h", got, 32'd0); end
        wb_read(2, got);
        tests++;
        if (got !== 32'h100) begin failed++; $display("FAIL empty_pushpop_status got=%h exp=%h", got, 32'h100); end
        wb_read(3, got);
        tests++;
        if (got !== 32'd77) begin failed++; $display("FAIL empty_pushpop_data got=%h exp=%h", got, 32'd77); end
    endtask

    task automatic test_mid_reset();
        logic [31:0] got;
        int          idxs [8] = '{0, 1, 2, 4, 5, 6, 7, 8};
        logic [31:0] exps [8] = '{32'h0, 32'h0, 32'h1, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
        wb_write(1, 32'd3);
        send(32'd1, 1'b0);
        send(32'd2, 1'b0);
        send(32'd3, 1'b0);
        wb_rst_i = 1'b1;
        send(32'd9, 1'b0);
        wb_rst_i = 1'b0;
        for (int i = 0; i < 8; i++) begin
            wb_read(idxs[i], got);
            tests++;
            if (got !== exps[i]) begin failed++; $display("FAIL rst_idx%0d got=%h exp=%h", idxs[i], got, exps[i]); end
        end
        tests++;
        if (int_o !== 1'b0) begin failed++; $display("FAIL rst_int got=%b exp=0", int_o); end
        send(32'd4, 1'b0);
        send(32'd5, 1'b0);
        wb_read(2, got);
        tests++;
        if (got !== 32'h1) begin failed++; $display("FAIL rst_ignored_status got=%h exp=%h", got, 32'h1); end
        wb_write(0, 32'h1);
        send(32'd5, 1'b1);
        wb_read(8, got);
        tests++;
        if (got !== 32'd1) begin failed++; $display("FAIL rst_reenable_count got=%h exp=%h", got, 32'd1); end
        wb_read(2, got);
        tests++;
        if (got !== 32'h108) begin failed++; $display("FAIL rst_reenable_status got=%h exp=%h", got, 32'h108); end
    endtask

    initial begin
        wb_rst_i   = 1'b1;
        in_valid_i = 1'b0;
        in_data_i  = '0;
        in_last_i  = 1'b0;
        wb_adr_i   = '0;
        wb_cyc_i   = 1'b0;
        wb_stb_i   = 1'b0;
        wb_we_i    = 1'b0;
        wb_sel_i   = 4'hF;
        wb_dat_i   = '0;
        repeat (2) @(posedge wb_clk_i);
        #1;
        wb_rst_i = 1'b0;

        test_reset();
        test_basic();
        test_decim();
        test_overflow();
        test_disable();
        test_sum_wrap();
        test_empty_pop();
        test_mid_reset();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
